// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Purpose : Shared types, constants and GF(2^8) helpers for the AES inverse core
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  localparam int         AES_ROUNDS   = 10;
  localparam logic [3:0] LAST_KEY_IDX = 4'd10;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// ============================================================================
// Module  : aes_inv_round
// Purpose : Combinational AES inverse round (InvShiftRows, InvSubBytes,
//           AddRoundKey, optional InvMixColumns)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_round
  import aes_pkg::*;
(
  input  aes_block_t state_in,
  input  aes_block_t roundKey,
  input  logic       skip_mix,
  output aes_block_t state_out
);

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  aes_block_t w_sub;
  aes_block_t w_ark;
  aes_block_t w_mix;

  // Byte index 4*c+r sits at bits [8*(15-idx) +: 8]; row r rotates right by r.
  always_comb begin
    w_sub = '0;
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sub[8*(15-(4*c+r)) +: 8] =
          inv_sbox(state_in[8*(15-(4*((c+4-r)%4)+r)) +: 8]);
      end
    end
    w_ark = w_sub ^ roundKey;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = w_ark[8*(15-4*c)   +: 8];
      a1 = w_ark[8*(14-4*c)   +: 8];
      a2 = w_ark[8*(13-4*c)   +: 8];
      a3 = w_ark[8*(12-4*c)   +: 8];
      w_mix[8*(15-4*c) +: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
      w_mix[8*(14-4*c) +: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
      w_mix[8*(13-4*c) +: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
      w_mix[8*(12-4*c) +: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end
  end

  assign state_out = skip_mix ? w_ark : w_mix;

endmodule

`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl.sv
// ============================================================================
// Module  : aes_inv_cipher_ctrl
// Purpose : Iterative AES-128 inverse-cipher sequencer, one round per clock
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_ROUNDS
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipherText,
  output logic [3:0]   key_round_idx,
  input  logic [127:0] roundKey,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plainText,
  output logic         busy
);

  ctrl_state_t r_state;
  aes_block_t  r_blk;
  aes_block_t  r_plain;
  logic [3:0]  r_round_cnt;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;

  aes_block_t  w_round_out;
  logic [3:0]  w_key_idx;

  always_comb begin
    w_key_idx = LAST_KEY_IDX;
    case (r_state)
      ROUND:   w_key_idx = r_round_cnt;
      FINAL:   w_key_idx = 4'd0;
      default: w_key_idx = LAST_KEY_IDX;
    endcase
  end

  aes_inv_round u_round (
    .state_in  (r_blk),
    .roundKey  (roundKey),
    .skip_mix  (r_state == FINAL),
    .state_out (w_round_out)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_blk       <= '0;
      r_plain     <= '0;
      r_round_cnt <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_blk       <= '0;
      r_plain     <= '0;
      r_round_cnt <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_blk       <= cipherText ^ roundKey;
            r_round_cnt <= 4'(NUM_ROUNDS - 1);
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ROUND;
          end
        end
        ROUND: begin
          r_blk <= w_round_out;
          // Guarding <=1 keeps the counter from ever wrapping through zero.
          if (r_round_cnt <= 4'd1) r_state <= FINAL;
          else                     r_round_cnt <= r_round_cnt - 4'd1;
        end
        FINAL: begin
          r_blk       <= w_round_out;
          r_plain     <= w_round_out;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_plain     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign busy          = r_busy;
  assign plainText     = r_plain;
  assign key_round_idx = w_key_idx;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_ctrl.sv
// ============================================================================
// Module  : tb_aes_inv_cipher_ctrl
// Purpose : Directed self-checking bench for aes_inv_cipher_ctrl (FIPS-197 vectors)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_inv_cipher_ctrl;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipherText;
  logic [3:0]   key_round_idx;
  logic [127:0] roundKey;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plainText;
  logic         busy;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0]   sbox [0:255];
  logic [127:0] rkA  [0:15];
  logic [127:0] rkB  [0:15];
  logic         key_sel;

  int n_checks = 0;
  int n_fail   = 0;

  assign roundKey = key_sel ? rkB[key_round_idx] : rkA[key_round_idx];

  aes_inv_cipher_ctrl dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .cipherText    (cipherText),
    .key_round_idx (key_round_idx),
    .roundKey      (roundKey),
    .clear         (clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .plainText     (plainText),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // Forward S-box from the log/antilog walk (generator 3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  initial begin
    bit           seen_ov;
    bit           stable;
    bit           got;
    int           acc [0:1];
    int           nacc;
    int           nout;
    int           sp;

    n_rst      = 1'b0;
    in_valid   = 1'b0;
    cipherText = '0;
    clear      = 1'b0;
    out_ready  = 1'b1;
    key_sel    = 1'b0;

    build_sbox();
    for (int r = 0; r < 16; r++) begin
      rkA[r] = (r <= 10) ? round_key(KEY_A, r) : '0;
      rkB[r] = (r <= 10) ? round_key(KEY_B, r) : '0;
    end

    // Reset state
    tick();
    tick();
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    chk("rst_plain",     plainText,       128'd0);
    chk("rst_key_idx",   128'(key_round_idx), 128'd10);
    n_rst = 1'b1;
    tick();

    // C.1 vector: latency and key index sequence
    cipherText = CT_A;
    in_valid   = 1'b1;
    chk("c1_idle_key_idx", 128'(key_round_idx), 128'd10);
    tick();
    in_valid = 1'b0;
    for (int i = 9; i >= 1; i--) begin
      chk($sformatf("c1_key_idx_%0d", i), 128'(key_round_idx), 128'(i));
      chk("c1_busy_mid",  128'({busy, in_ready, out_valid}), 128'b100);
      chk("c1_plain_mid", plainText, 128'd0);
      tick();
    end
    chk("c1_key_idx_0",    128'(key_round_idx), 128'd0);
    chk("c1_ov_before_10", 128'(out_valid), 128'd0);
    tick();
    chk("c1_ov_at_10", 128'(out_valid), 128'd1);
    chk("c1_plain",    plainText, PT_A);
    tick();
    chk("c1_back_idle", 128'({in_ready, out_valid, busy}), 128'b100);
    chk("c1_plain_cleared", plainText, 128'd0);

    // Backpressure with a busy-time block that must be ignored
    out_ready  = 1'b0;
    cipherText = CT_A;
    in_valid   = 1'b1;
    tick();
    cipherText = '0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready_busy", 128'(in_ready), 128'd0);
      tick();
    end
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else tick();
    end
    chk("bp_out_valid_seen", 128'(got), 128'd1);
    chk("bp_plain", plainText, PT_A);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(out_valid && plainText === PT_A && !in_ready && busy)) stable = 1'b0;
    end
    chk("bp_held_stable", 128'(stable), 128'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_release_idle", 128'({in_ready, out_valid, busy}), 128'b100);

    // Async reset in the middle of round 5
    cipherText = CT_A;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ar_round5_idx", 128'(key_round_idx), 128'd5);
    #2;
    n_rst = 1'b0;
    #1;
    chk("ar_flags",   128'({in_ready, out_valid, busy}), 128'b100);
    chk("ar_plain",   plainText, 128'd0);
    chk("ar_key_idx", 128'(key_round_idx), 128'd10);
    tick();
    #2;
    n_rst = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    chk("ar_no_spurious_ov", 128'(seen_ov), 128'd0);

    // clear during FINAL
    cipherText = CT_A;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("cl_in_final", 128'(key_round_idx), 128'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cl_idle_flags", 128'({in_ready, out_valid, busy}), 128'b100);
    chk("cl_plain",      plainText, 128'd0);
    seen_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    chk("cl_no_ov", 128'(seen_ov), 128'd0);

    // clear beats acceptance, then a fresh block (Appendix B key) decrypts
    key_sel    = 1'b1;
    cipherText = CT_B;
    in_valid   = 1'b1;
    clear      = 1'b1;
    tick();
    clear = 1'b0;
    chk("cl_priority", 128'({in_ready, busy}), 128'b10);
    tick();
    in_valid = 1'b0;
    chk("cl_new_accept", 128'(busy), 128'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("cl_new_ov",    128'(out_valid), 128'd1);
    chk("cl_new_plain", plainText, PT_B);
    tick();

    // Back-to-back with in_valid held high
    key_sel    = 1'b0;
    cipherText = CT_A;
    in_valid   = 1'b1;
    nacc = 0;
    nout = 0;
    acc[0] = 0;
    acc[1] = 0;
    for (int c = 0; c < 60 && nout < 2; c++) begin
      if (in_ready && in_valid && nacc < 2) begin
        acc[nacc] = c;
        nacc++;
      end
      if (out_valid) begin
        chk($sformatf("b2b_plain_%0d", nout), plainText, (nout == 0) ? PT_A : PT_B);
        nout++;
        key_sel    = 1'b1;
        cipherText = CT_B;
        if (nout == 2) in_valid = 1'b0;
      end
      tick();
    end
    chk("b2b_outputs", 128'(nout), 128'd2);
    chk("b2b_accepts", 128'(nacc), 128'd2);
    sp = acc[1] - acc[0];
    // E0 accept, E10 result, E11 handoff, one IDLE cycle before the next accept
    chk("b2b_spacing", 128'(sp >= 11 && sp <= 12), 128'd1);
    chk("b2b_idle_end", 128'({in_ready, out_valid, busy}), 128'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
